term_ctrl: RTL



---
 rtl/term_pkg.sv | 21 ++
 rtl/term_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared constants and enums for the terminal controller
package term_pkg;

  localparam int ADDR_W = 11;

  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_TAB = 8'h09;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_FF  = 8'h0C;
  localparam logic [7:0] CHR_CR  = 8'h0D;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // OP_FILL blanks the bottom row after a scroll; OP_CLEAR blanks the whole screen
  typedef enum logic [1:0] {OP_CHAR, OP_COPY, OP_FILL, OP_CLEAR} op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/term_ctrl.sv
// rtl/term_ctrl.sv - byte-stream terminal controller driving the block-write engine (TAB via TERM_TAB_EN)
module term_ctrl
  import term_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter logic [7:0] BLANK      = 8'h20,
  parameter logic [7:0] GLYPH_BIAS = 8'd1
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_begin,
  output logic [ADDR_W-1:0] wr_end,
  output logic [7:0]        wr_data,
  output logic [7:0]        wr_offset,
  input  logic              wr_complete,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ROW_ADDR = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] SCREEN_END    = ADDR_W'(ROWS * COLS);
  localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW      = 5'(ROWS - 1);
  localparam logic [7:0]        BLANK_GLYPH   = BLANK + GLYPH_BIAS;
  localparam logic [7:0]        ROW_OFFSET    = 8'(COLS);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [6:0]        col_d;
  logic [4:0]        row_d;
  logic [ADDR_W-1:0] begin_d, end_d;
  logic [7:0]        data_d, offset_d;
  logic [ADDR_W-1:0] cur_addr;

  assign in_ready = (state_q == IDLE) && !rst;
  assign wr_start = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign cur_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

`ifdef TERM_TAB_EN
  logic [7:0] tab_sum;
  logic [6:0] tab_col;
  // next tab stop is the following multiple of 8, clamped to the last column
  always_comb begin
    tab_sum = {1'b0, cursor_col | 7'd7} + 8'd1;
    tab_col = (tab_sum > {1'b0, LAST_COL}) ? LAST_COL : tab_sum[6:0];
  end
`endif

  // sequencer: decodes accepted bytes, chains write/copy/fill, updates cursor on completion
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    col_d    = cursor_col;
    row_d    = cursor_row;
    begin_d  = wr_begin;
    end_d    = wr_end;
    data_d   = wr_data;
    offset_d = wr_offset;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (is_printable(in_data)) begin
            op_d     = OP_CHAR;
            begin_d  = cur_addr;
            end_d    = cur_addr + ADDR_W'(1);
            data_d   = in_data + GLYPH_BIAS;
            offset_d = 8'd0;
            state_d  = ISSUE;
          end else begin
            case (in_data)
              CHR_CR: col_d = 7'd0;
              CHR_BS: if (cursor_col != 7'd0) col_d = cursor_col - 7'd1;
              CHR_LF: begin
                if (cursor_row != LAST_ROW) begin
                  row_d = cursor_row + 5'd1;
                end else begin
                  op_d     = OP_COPY;
                  begin_d  = '0;
                  end_d    = LAST_ROW_ADDR;
                  data_d   = 8'd0;
                  offset_d = ROW_OFFSET;
                  state_d  = ISSUE;
                end
              end
              CHR_FF: begin
                op_d     = OP_CLEAR;
                begin_d  = '0;
                end_d    = SCREEN_END;
                data_d   = BLANK_GLYPH;
                offset_d = 8'd0;
                state_d  = ISSUE;
              end
`ifdef TERM_TAB_EN
              CHR_TAB: col_d = tab_col;
`endif
              default: ;
            endcase
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (wr_complete) begin
          state_d = IDLE;
          case (op_q)
            OP_CHAR: begin
              if (cursor_col != LAST_COL) begin
                col_d = cursor_col + 7'd1;
              end else begin
                col_d = 7'd0;
                if (cursor_row != LAST_ROW) begin
                  row_d = cursor_row + 5'd1;
                end else begin
                  op_d     = OP_COPY;
                  begin_d  = '0;
                  end_d    = LAST_ROW_ADDR;
                  data_d   = 8'd0;
                  offset_d = ROW_OFFSET;
                  state_d  = ISSUE;
                end
              end
            end
            OP_COPY: begin
              op_d     = OP_FILL;
              begin_d  = LAST_ROW_ADDR;
              end_d    = SCREEN_END;
              data_d   = BLANK_GLYPH;
              offset_d = 8'd0;
              state_d  = ISSUE;
            end
            OP_FILL: ;
            OP_CLEAR: begin
              col_d = 7'd0;
              row_d = 5'd0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, cursor and engine fields; reset abandons any operation in flight
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_CHAR;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
      wr_begin   <= '0;
      wr_end     <= '0;
      wr_data    <= 8'd0;
      wr_offset  <= 8'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      wr_begin   <= begin_d;
      wr_end     <= end_d;
      wr_data    <= data_d;
      wr_offset  <= offset_d;
    end
  end

endmodule
